// File: rtl/axi_burst_slv_sram.sv
// AXI4 burst slave over a behavioural SRAM: FIXED/INCR/WRAP bursts, narrow transfers,
// independent read and write engines, SLVERR for out-of-window or malformed bursts.
module axi_burst_slv_sram #(
  parameter int          DW   = 128,
  parameter int          AW   = 14,
  parameter logic [31:0] BASE = 32'h8000_0000
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [31:0]     MEM_AWADDR,
  input  logic [7:0]      MEM_AWLEN,
  input  logic [2:0]      MEM_AWSIZE,
  input  logic [1:0]      MEM_AWBURST,
  input  logic            MEM_AWVALID,
  output logic            MEM_AWREADY,
  input  logic [DW-1:0]   MEM_WDATA,
  input  logic [DW/8-1:0] MEM_WSTRB,
  input  logic            MEM_WLAST,
  input  logic            MEM_WVALID,
  output logic            MEM_WREADY,
  output logic [1:0]      MEM_BRESP,
  output logic            MEM_BVALID,
  input  logic            MEM_BREADY,
  input  logic [31:0]     MEM_ARADDR,
  input  logic [7:0]      MEM_ARLEN,
  input  logic [2:0]      MEM_ARSIZE,
  input  logic [1:0]      MEM_ARBURST,
  input  logic            MEM_ARVALID,
  output logic            MEM_ARREADY,
  output logic [DW-1:0]   MEM_RDATA,
  output logic [1:0]      MEM_RRESP,
  output logic            MEM_RLAST,
  output logic            MEM_RVALID,
  input  logic            MEM_RREADY
);

  localparam int          NB  = DW / 8;
  localparam int          NBL = $clog2(NB);
  localparam logic [63:0] WIN = 64'(NB) << AW;

  // Handshakes: a transfer happens on the rising CLK edge where valid and ready are both 1;
  // valid never waits on ready, and payload is held while valid & !ready.

  function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || (int'(size) > NBL) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  function automatic logic out_of_win(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (addr < BASE) || ({32'b0, off} >= WIN);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return off[NBL +: AW];
  endfunction

  function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] bytes;
    logic [31:0] mask;
    logic [31:0] nxt;
    bytes = 32'd1 << size;
    mask  = bytes * ({24'b0, len} + 32'd1) - 32'd1;
    case (burst)
      2'b01:   nxt = (addr & ~(bytes - 32'd1)) + bytes;
      2'b10:   nxt = (addr & ~mask) | ((addr + bytes) & mask);
      default: nxt = addr;
    endcase
    return nxt;
  endfunction

  // ---------------- write engine ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t    w_state, w_state_nxt;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_beat;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_bad, w_err;
  logic        aw_hs, w_hs, w_last_beat, w_beat_err, mem_we;

  assign aw_hs       = MEM_AWVALID & MEM_AWREADY;
  assign w_hs        = MEM_WVALID & MEM_WREADY;
  assign w_last_beat = (w_beat == w_len);
  assign w_beat_err  = w_bad | out_of_win(w_addr);
  assign mem_we      = w_hs & ~w_beat_err;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    MEM_AWREADY = 1'b0;
    MEM_WREADY  = 1'b0;
    MEM_BVALID  = 1'b0;
    MEM_BRESP   = 2'b00;
    case (w_state)
      W_IDLE: begin
        MEM_AWREADY = 1'b1;
        if (MEM_AWVALID) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        MEM_WREADY = 1'b1;
        if (MEM_WVALID && w_last_beat) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        MEM_BVALID = 1'b1;
        MEM_BRESP  = {w_err, 1'b0};
        if (MEM_BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_beat  <= '0;
      w_bad   <= 1'b0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_addr  <= MEM_AWADDR;
      w_len   <= MEM_AWLEN;
      w_size  <= MEM_AWSIZE;
      w_burst <= MEM_AWBURST;
      w_beat  <= '0;
      w_bad   <= burst_bad(MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST);
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= step_addr(w_addr, w_len, w_size, w_burst);
      w_beat <= w_beat + 8'd1;
      // A WLAST that disagrees with the beat count is flagged but does not end the burst.
      if (w_beat_err || (MEM_WLAST != w_last_beat)) w_err <= 1'b1;
    end
  end

  // ---------------- read engine ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t    r_state, r_state_nxt;
  logic [31:0] r_addr, r_next, rd_addr;
  logic [7:0]  r_len, r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_bad, r_err;
  logic        ar_hs, r_hs, r_last, rd_en, ar_bad;
  logic [DW-1:0] rd_q;

  assign ar_hs   = MEM_ARVALID & MEM_ARREADY;
  assign r_hs    = MEM_RVALID & MEM_RREADY;
  assign r_last  = (r_beat == r_len);
  assign r_next  = step_addr(r_addr, r_len, r_size, r_burst);
  assign ar_bad  = burst_bad(MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST);
  // The read port only fetches on AR acceptance or on a beat that is not the last,
  // so a stalled beat keeps its data.
  assign rd_addr = (r_state == R_IDLE) ? MEM_ARADDR : r_next;
  assign rd_en   = ar_hs | (r_hs & ~r_last);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    MEM_ARREADY = 1'b0;
    MEM_RVALID  = 1'b0;
    MEM_RLAST   = 1'b0;
    MEM_RRESP   = 2'b00;
    MEM_RDATA   = '0;
    case (r_state)
      R_IDLE: begin
        MEM_ARREADY = 1'b1;
        if (MEM_ARVALID) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        MEM_RVALID = 1'b1;
        MEM_RLAST  = r_last;
        MEM_RRESP  = {r_err, 1'b0};
        MEM_RDATA  = r_err ? '0 : rd_q;
        if (MEM_RREADY && r_last) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
    end else if (ar_hs) begin
      r_addr  <= MEM_ARADDR;
      r_len   <= MEM_ARLEN;
      r_size  <= MEM_ARSIZE;
      r_burst <= MEM_ARBURST;
      r_beat  <= '0;
      r_bad   <= ar_bad;
      r_err   <= ar_bad | out_of_win(MEM_ARADDR);
    end else if (r_hs && !r_last) begin
      r_addr <= r_next;
      r_beat <= r_beat + 8'd1;
      r_err  <= r_bad | out_of_win(r_next);
    end
  end

  // ---------------- storage (never reset; read sees pre-write data) ----------------
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (MEM_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= MEM_WDATA[8*b +: 8];
      end
    end
    if (rd_en) rd_q <= mem[word_idx(rd_addr)];
  end

endmodule

// File: tb/tb_axi_burst_slv_sram.sv
// Directed bench for axi_burst_slv_sram: round trips, WRAP order, narrow writes,
// error responses, read backpressure and asynchronous reset mid-burst.
module tb_axi_burst_slv_sram;

  localparam int DW = 128;
  localparam int NB = DW / 8;
  localparam int AW = 14;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  logic          CLK, RSTn;
  logic [31:0]   MEM_AWADDR, MEM_ARADDR;
  logic [7:0]    MEM_AWLEN, MEM_ARLEN;
  logic [2:0]    MEM_AWSIZE, MEM_ARSIZE;
  logic [1:0]    MEM_AWBURST, MEM_ARBURST;
  logic          MEM_AWVALID, MEM_AWREADY, MEM_ARVALID, MEM_ARREADY;
  logic [DW-1:0] MEM_WDATA, MEM_RDATA;
  logic [NB-1:0] MEM_WSTRB;
  logic          MEM_WLAST, MEM_WVALID, MEM_WREADY;
  logic [1:0]    MEM_BRESP, MEM_RRESP;
  logic          MEM_BVALID, MEM_BREADY;
  logic          MEM_RLAST, MEM_RVALID, MEM_RREADY;

  axi_burst_slv_sram #(.DW(DW), .AW(AW), .BASE(32'h8000_0000)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN), .MEM_AWSIZE(MEM_AWSIZE),
    .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
    .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
    .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
    .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN), .MEM_ARSIZE(MEM_ARSIZE),
    .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
    .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
    .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wd[16];
  logic [NB-1:0] ws[16];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                       input logic [1:0] bu);
    int n;
    n = 0;
    MEM_AWADDR = a; MEM_AWLEN = len; MEM_AWSIZE = sz; MEM_AWBURST = bu; MEM_AWVALID = 1'b1;
    while (!MEM_AWREADY && n < 50) begin @(posedge CLK); #1; n++; end
    chk("awready_wait", MEM_AWREADY, 1'b1);
    @(posedge CLK); #1;
    MEM_AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [7:0] len, input bit bad_last);
    for (int k = 0; k <= int'(len); k++) begin
      MEM_WDATA  = wd[k];
      MEM_WSTRB  = ws[k];
      MEM_WLAST  = (k == int'(len)) ^ (bad_last && k == 0);
      MEM_WVALID = 1'b1;
      chk("wready", MEM_WREADY, 1'b1);
      @(posedge CLK); #1;
    end
    MEM_WVALID = 1'b0;
    MEM_WLAST  = 1'b0;
    chk("bvalid_latency", MEM_BVALID, 1'b1);
  endtask

  task automatic do_b(input logic [1:0] exp_resp);
    chk("bresp", MEM_BRESP, exp_resp);
    @(posedge CLK); #1;
    chk("bvalid_hold", MEM_BVALID, 1'b1);
    MEM_BREADY = 1'b1;
    @(posedge CLK); #1;
    MEM_BREADY = 1'b0;
    chk("bvalid_drop", MEM_BVALID, 1'b0);
    chk("awready_idle", MEM_AWREADY, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input bit bad_last, input logic [1:0] exp_resp);
    do_aw(a, len, sz, bu);
    do_w(len, bad_last);
    do_b(exp_resp);
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                       input logic [1:0] bu);
    int n;
    n = 0;
    MEM_ARADDR = a; MEM_ARLEN = len; MEM_ARSIZE = sz; MEM_ARBURST = bu; MEM_ARVALID = 1'b1;
    while (!MEM_ARREADY && n < 50) begin @(posedge CLK); #1; n++; end
    chk("arready_wait", MEM_ARREADY, 1'b1);
    @(posedge CLK); #1;
    MEM_ARVALID = 1'b0;
    chk("rvalid_latency", MEM_RVALID, 1'b1);
  endtask

  task automatic rd_beat(input logic [1:0] exp_resp, input bit exp_last);
    logic [DW-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("rvalid", MEM_RVALID, 1'b1);
    chk("rdata", MEM_RDATA, e);
    chk("rresp", MEM_RRESP, exp_resp);
    chk("rlast", MEM_RLAST, exp_last);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [1:0] exp_resp);
    do_ar(a, len, sz, bu);
    MEM_RREADY = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      rd_beat(exp_resp, b == int'(len));
      @(posedge CLK); #1;
    end
    MEM_RREADY = 1'b0;
    chk("rvalid_drop", MEM_RVALID, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  logic [DW-1:0] d[4], p[4], nw[4];
  logic [DW-1:0] p0f, p10, p11, z0, q0, q1, narrow_exp;

  initial begin
    for (int k = 0; k < 4; k++) begin
      d[k]  = {4{32'hD000_0000 + 32'(k)}};
      p[k]  = {4{32'h5A5A_0000 + 32'(k)}};
      nw[k] = {4{32'hC0DE_0000 + 32'(k)}};
    end
    p0f = {4{32'h0F0F_0F0F}};
    p10 = {4{32'hAAAA_5555}};
    p11 = {4{32'h1234_5678}};
    z0  = {4{32'hCAFE_F00D}};
    q0  = {4{32'h0BAD_0000}};
    q1  = {4{32'h0BAD_0001}};
    narrow_exp = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    RSTn = 1'b0;
    MEM_AWADDR = '0; MEM_AWLEN = '0; MEM_AWSIZE = '0; MEM_AWBURST = '0; MEM_AWVALID = 1'b0;
    MEM_WDATA = '0; MEM_WSTRB = '0; MEM_WLAST = 1'b0; MEM_WVALID = 1'b0; MEM_BREADY = 1'b0;
    MEM_ARADDR = '0; MEM_ARLEN = '0; MEM_ARSIZE = '0; MEM_ARBURST = '0; MEM_ARVALID = 1'b0;
    MEM_RREADY = 1'b0;

    // reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_awready", MEM_AWREADY, 1'b1);
    chk("rst_arready", MEM_ARREADY, 1'b1);
    chk("rst_wready", MEM_WREADY, 1'b0);
    chk("rst_bvalid", MEM_BVALID, 1'b0);
    chk("rst_rvalid", MEM_RVALID, 1'b0);
    chk("rst_rlast", MEM_RLAST, 1'b0);
    chk("rst_bresp", MEM_BRESP, 2'b00);
    chk("rst_rresp", MEM_RRESP, 2'b00);
    chk("rst_rdata", MEM_RDATA, '0);
    RSTn = 1'b1;
    @(posedge CLK); #1;

    // INCR round trip: words 4..7
    for (int k = 0; k < 4; k++) begin wd[k] = d[k]; ws[k] = 16'hFFFF; end
    do_write(32'h8000_0040, 8'd3, 3'd4, INCR, 1'b0, 2'b00);
    for (int k = 0; k < 4; k++) exp_q.push_back(d[k]);
    do_read(32'h8000_0040, 8'd3, 3'd4, INCR, 2'b00);

    // WRAP read from word 7 wraps to 4, 5, 6
    exp_q.push_back(d[3]); exp_q.push_back(d[0]); exp_q.push_back(d[1]); exp_q.push_back(d[2]);
    do_read(32'h8000_0070, 8'd3, 3'd4, WRAP, 2'b00);

    // FIXED read repeats the same word
    exp_q.push_back(d[1]); exp_q.push_back(d[1]);
    do_read(32'h8000_0050, 8'd1, 3'd4, FIXED, 2'b00);

    // narrow INCR write into word 0x10 with neighbours 0x0F and 0x11 preloaded
    wd[0] = p0f; wd[1] = p10; wd[2] = p11;
    ws[0] = 16'hFFFF; ws[1] = 16'hFFFF; ws[2] = 16'hFFFF;
    do_write(32'h8000_00F0, 8'd2, 3'd4, INCR, 1'b0, 2'b00);
    wd[0] = {4{32'h1111_1111}}; ws[0] = 16'h000F;
    wd[1] = {4{32'h2222_2222}}; ws[1] = 16'h00F0;
    wd[2] = {4{32'h3333_3333}}; ws[2] = 16'h0F00;
    wd[3] = {4{32'h4444_4444}}; ws[3] = 16'hF000;
    do_write(32'h8000_0100, 8'd3, 3'd2, INCR, 1'b0, 2'b00);
    exp_q.push_back(p0f); exp_q.push_back(narrow_exp); exp_q.push_back(p11);
    do_read(32'h8000_00F0, 8'd2, 3'd4, INCR, 2'b00);

    // out-of-window: word 0 holds z0; a write one past the window must not touch it
    wd[0] = z0; ws[0] = 16'hFFFF;
    do_write(32'h8000_0000, 8'd0, 3'd4, INCR, 1'b0, 2'b00);
    wd[0] = {4{32'hDEAD_BEEF}};
    do_write(32'h8004_0000, 8'd0, 3'd4, INCR, 1'b0, 2'b10);
    exp_q.push_back('0);
    do_read(32'h8004_0000, 8'd0, 3'd4, INCR, 2'b10);
    exp_q.push_back(z0);
    do_read(32'h8000_0000, 8'd0, 3'd4, INCR, 2'b00);
    exp_q.push_back('0);
    do_read(32'h7FFF_FFF0, 8'd0, 3'd4, INCR, 2'b10);

    // malformed bursts: WRAP len 2, reserved burst type, size wider than the bus
    for (int k = 0; k < 3; k++) exp_q.push_back('0);
    do_read(32'h8000_0000, 8'd2, 3'd4, WRAP, 2'b10);
    exp_q.push_back('0);
    do_read(32'h8000_0040, 8'd0, 3'd4, 2'b11, 2'b10);
    wd[0] = {4{32'hFFFF_0000}};
    do_write(32'h8000_0000, 8'd0, 3'd5, INCR, 1'b0, 2'b10);
    exp_q.push_back(z0);
    do_read(32'h8000_0000, 8'd0, 3'd4, INCR, 2'b00);

    // WLAST mismatch: flagged in BRESP, data still lands
    wd[0] = q0; wd[1] = q1; ws[0] = 16'hFFFF; ws[1] = 16'hFFFF;
    do_write(32'h8000_0300, 8'd1, 3'd4, INCR, 1'b1, 2'b10);
    exp_q.push_back(q0); exp_q.push_back(q1);
    do_read(32'h8000_0300, 8'd1, 3'd4, INCR, 2'b00);

    // read backpressure on beat 1
    do_ar(32'h8000_0040, 8'd3, 3'd4, INCR);
    MEM_RREADY = 1'b1;
    exp_q.push_back(d[0]);
    rd_beat(2'b00, 1'b0);
    @(posedge CLK); #1;
    MEM_RREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(d[1]);
      rd_beat(2'b00, 1'b0);
      @(posedge CLK); #1;
    end
    MEM_RREADY = 1'b1;
    for (int b = 1; b < 4; b++) begin
      exp_q.push_back(d[b]);
      rd_beat(2'b00, b == 3);
      @(posedge CLK); #1;
    end
    MEM_RREADY = 1'b0;
    chk("bp_rvalid_drop", MEM_RVALID, 1'b0);

    // asynchronous reset after W beat 1 of a 4-beat burst
    for (int k = 0; k < 4; k++) begin wd[k] = p[k]; ws[k] = 16'hFFFF; end
    do_write(32'h8000_0200, 8'd3, 3'd4, INCR, 1'b0, 2'b00);
    do_aw(32'h8000_0200, 8'd3, 3'd4, INCR);
    for (int k = 0; k < 2; k++) begin
      MEM_WDATA = nw[k]; MEM_WSTRB = 16'hFFFF; MEM_WLAST = 1'b0; MEM_WVALID = 1'b1;
      chk("rstw_wready", MEM_WREADY, 1'b1);
      @(posedge CLK); #1;
    end
    RSTn = 1'b0;
    #1;
    chk("async_wready", MEM_WREADY, 1'b0);
    chk("async_bvalid", MEM_BVALID, 1'b0);
    chk("async_awready", MEM_AWREADY, 1'b1);
    MEM_WVALID = 1'b0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
    chk("post_rst_awready", MEM_AWREADY, 1'b1);
    chk("post_rst_arready", MEM_ARREADY, 1'b1);
    exp_q.push_back(nw[0]); exp_q.push_back(nw[1]); exp_q.push_back(p[2]); exp_q.push_back(p[3]);
    do_read(32'h8000_0200, 8'd3, 3'd4, INCR, 2'b00);

    chk("exp_q_drained", DW'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_slv_sram.md
# axi_burst_slv_sram

Parametrised AXI4 burst slave backed by a behavioural SRAM array; the next-generation memory model for the chip-level bench and for FPGA bring-up. It is the target of the core's 128-bit memory channel. Compared with the fixed-function slave it adds:
- FIXED, INCR and WRAP bursts
- narrow transfers via AxSIZE
- independent read and write engines
- SLVERR reporting for out-of-window addresses and malformed bursts.

## Interface
Parameters:
- DW, 128: data width in bits; power of two, 32..512. NB = DW/8 bytes per word.
- AW, 14: word-address bits; depth is 2^AW words.
- BASE, 32'h8000_0000: byte address of word 0; NB-aligned.

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset; one clock; reset is asynchronous and active-low
- MEM_AWADDR in 32; MEM_AWLEN in 8; MEM_AWSIZE in 3; MEM_AWBURST in 2; MEM_AWVALID in 1; MEM_AWREADY out 1
- MEM_WDATA in DW; MEM_WSTRB in DW/8; MEM_WLAST in 1; MEM_WVALID in 1; MEM_WREADY out 1
- MEM_BRESP out 2; MEM_BVALID out 1; MEM_BREADY in 1
- MEM_ARADDR in 32; MEM_ARLEN in 8; MEM_ARSIZE in 3; MEM_ARBURST in 2; MEM_ARVALID in 1; MEM_ARREADY out 1
- MEM_RDATA out DW; MEM_RRESP out 2; MEM_RLAST out 1; MEM_RVALID out 1; MEM_RREADY in 1

## Operation
- **Storage.** Array of 2^AW words of DW bits, with one write port and one registered read port. The array is never reset.
- **Engines.** Write and read engines are independent and may run concurrently.
- **Same-word collision.** If a write and a read hit the same word in the same cycle, the read returns the pre-write data.
- **Write FSM.**
  - W_IDLE → W_DATA on AWVALID & AWREADY. This latches addr, len, size and burst, clears the beat counter and clears the sticky error.
  - W_DATA → W_RESP on the W handshake of beat len.
  - W_RESP → W_IDLE on BVALID & BREADY.
- **Read FSM.**
  - R_IDLE → R_DATA on AR handshake.
  - R_DATA → R_IDLE on the R handshake with RLAST = 1.
- **Write beat.** Writes each byte lane whose WSTRB bit is set, unless the beat is in error. WSTRB is used as given; lanes are not masked by size.
- **Read beat.** Returns the full DW-bit word. RDATA = 0 on an error beat.
- **Beat address.** beat addr → word index = (addr − BASE) >> log2(NB).
  - Out of window when addr < BASE or addr − BASE ≥ NB·2^AW.
- **Address step.** Let bytes = 2^size.
  - FIXED: addr is unchanged.
  - INCR: next = (addr & ~(bytes−1)) + bytes. The first beat may be unaligned.
  - WRAP: mask = bytes·(len+1) − 1; next = (addr & ~mask) | ((addr + bytes) & mask).
  - Address arithmetic is 32-bit and wraps modulo 2^32.
- **Burst-level errors.** Any of the following marks every beat of the burst as an error:
  - burst = 2'b11
  - bytes > NB
  - WRAP with len ∉ {1, 3, 7, 15}
- **Response codes.** Beat error → RRESP = 2'b10 for that beat (otherwise 2'b00). On writes the error sets a sticky flag, giving BRESP = 2'b10 (otherwise 2'b00).
- **WLAST check.** A WLAST value that does not match (beat == len) sets the sticky write error. The burst still terminates on the beat count.

## Timing
- **Reset values.** AWREADY = 1 and ARREADY = 1 (idle states); WREADY, BVALID, RVALID, RLAST = 0; BRESP, RRESP = 0; RDATA = 0.
- **Async reset.** Asserting RSTn forces both FSMs to idle immediately, at any point, including mid-burst. Beats already written stay in the array.
- **Ready signals.** AWREADY = (W_IDLE); WREADY = (W_DATA); ARREADY = (R_IDLE).
- **Write burst.** The first W beat can be accepted the cycle after the AW handshake, and beats complete back-to-back. BVALID rises the cycle after the last W handshake and is held until BREADY.
- **AW acceptance.** A new AW is accepted only from W_IDLE, so there is a 1-cycle bubble after the B handshake.
- **Read latency.** RVALID rises the cycle after the AR handshake, carrying beat 0.
- **Read throughput.** With RREADY held high, one beat per cycle.
- **Read stall.** While RVALID & !RREADY, RDATA, RRESP and RLAST are held stable and the read address does not advance.
- **End of read burst.** RLAST = 1 exactly on beat len. RVALID drops the cycle after that handshake. The next AR can be accepted the cycle after RVALID drops.

## Test plan
1. **INCR round trip.** Write INCR, len = 3, size = 4, AWADDR 0x8000_0040, data D0..D3, WSTRB 0xFFFF.
   → BVALID one cycle after the 4th W handshake, BRESP = 0.
   Then read the same burst → RVALID the cycle after AR, data D0..D3, RLAST on beat 3 only, RRESP = 0.
2. **WRAP read.** Read WRAP, len = 3, size = 4, ARADDR 0x8000_0070.
   → Data from word indices 7, 4, 5, 6 in that order.
3. **Narrow INCR write.** Write INCR, len = 3, size = 2, AWADDR 0x8000_0100, WSTRB 0x000F, 0x00F0, 0x0F00, 0xF000.
   → Word 0x10 is fully updated; words 0x0F and 0x11 are unchanged.
4. **Out-of-window access.** Write INCR, len = 0 at BASE + NB·2^AW.
   → BRESP = 2'b10, array unchanged.
   Read at the same address → RRESP = 2'b10, RDATA = 0. A WRAP with len = 2 also gives 2'b10.
5. **Read backpressure.** Drive RREADY low for 3 cycles at beat 1 of a len = 3 read.
   → RVALID stays high; RDATA and RLAST are stable; no beat is lost or duplicated.
6. **Reset mid-burst.** Pull RSTn low after W beat 1 of len = 3.
   → WREADY and BVALID are 0 without waiting for CLK.
   After release: AWREADY = 1, beats 0–1 are present in memory, beats 2–3 are not.
